// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl
//   Latches a 4-bit word and steps a 2-bit select through positions 0..3 so
//   that an external 4:1 mux presents each bit of the word in turn. Each
//   position is held for DWELL cycles. A one-cycle done pulse follows the
//   last position, then the block returns to idle and accepts the next word.
//   A zero word skips the scan and goes straight to the done pulse.
//
// Parameters
//   DWELL        cycles each select position is held (1..16)
// Ports
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   in_valid     upstream offers a word
//   in_data      word to scan out
//   in_ready     high in idle; a word is accepted when in_valid is also high
//   d            latched word, held until the next accept
//   s            mux select
//   scan_active  high while s is stepping through positions
//   scan_done    one-cycle pulse after the last position
module mux_scan_ctrl #(
  parameter int DWELL = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [3:0] in_data,
  output logic       in_ready,
  output logic [3:0] d,
  output logic [1:0] s,
  output logic       scan_active,
  output logic       scan_done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  // Five bits hold DWELL-1 for every legal DWELL up to 16.
  localparam logic [4:0] CNT_LAST = 5'(DWELL - 1);

  state_t     state_q;
  logic [3:0] d_q;
  logic [1:0] s_q;
  logic [4:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      d_q     <= 4'd0;
      s_q     <= 2'd0;
      cnt_q   <= 5'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            d_q     <= in_data;
            s_q     <= 2'd0;
            cnt_q   <= 5'd0;
            // Nothing to scan for a zero word: signal completion directly.
            state_q <= (in_data == 4'd0) ? DONE : SCAN;
          end
        end
        SCAN: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q <= 5'd0;
            // s stays at 3 through the done cycle; it never wraps in SCAN.
            if (s_q == 2'd3) begin
              state_q <= DONE;
            end else begin
              s_q <= s_q + 2'd1;
            end
          end else begin
            cnt_q <= cnt_q + 5'd1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          s_q     <= 2'd0;
        end
        default: begin
          state_q <= IDLE;
          s_q     <= 2'd0;
          cnt_q   <= 5'd0;
        end
      endcase
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign scan_active = (state_q == SCAN);
  assign scan_done   = (state_q == DONE);
  assign d           = d_q;
  assign s           = s_q;

endmodule
